// File: rtl/clint_rtc_gen.sv
// Fractional-divider RTC source for the CLINT: a phase accumulator whose carry toggles rtc_o.
// Increment updates are staged and only applied at a rising edge, on disable, or while idle.
module clint_rtc_gen #(
    parameter int                   ACC_WIDTH   = 32,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 32'h0000_8637,
    parameter int                   CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [ACC_WIDTH-1:0] cfg_inc_i,
    output logic                 rtc_o,
    output logic                 tick_o,
    output logic [CNT_WIDTH-1:0] edge_cnt_o
);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] inc_reg;
    logic                 pend_reg;
    logic [ACC_WIDTH-1:0] pend_inc_reg;
    logic                 rtc_reg;
    logic                 tick_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;

    logic [ACC_WIDTH:0]   sum_next;
    logic                 carry_next;
    logic                 rise_next;
    logic                 xfer_next;
    logic                 apply_next;

    always_comb begin
        sum_next   = {1'b0, acc_reg} + {1'b0, inc_reg};
        carry_next = en_i & sum_next[ACC_WIDTH];
        rise_next  = carry_next & ~rtc_reg;
        xfer_next  = cfg_valid_i & cfg_ready_o;
        // A zero increment never carries, so waiting for a rise would stall the update forever.
        apply_next = pend_reg & (rise_next | ~en_i | (inc_reg == '0));
    end

    assign cfg_ready_o = ~rst_i & ~pend_reg;
    assign rtc_o       = rtc_reg;
    assign tick_o      = tick_reg;
    assign edge_cnt_o  = cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg      <= '0;
            inc_reg      <= DEFAULT_INC;
            pend_reg     <= 1'b0;
            pend_inc_reg <= '0;
            rtc_reg      <= 1'b0;
            tick_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            if (xfer_next) begin
                pend_reg     <= 1'b1;
                pend_inc_reg <= cfg_inc_i;
            end else if (apply_next) begin
                pend_reg <= 1'b0;
                inc_reg  <= pend_inc_reg;
            end

            if (en_i) begin
                acc_reg  <= sum_next[ACC_WIDTH-1:0];
                tick_reg <= rise_next;
                if (carry_next) begin
                    rtc_reg <= ~rtc_reg;
                end
                if (rise_next) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                acc_reg  <= '0;
                rtc_reg  <= 1'b0;
                tick_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clint_rtc_gen.sv
// Scoreboard bench for clint_rtc_gen at W=8, CNT_WIDTH=4, DEFAULT_INC=64.
module tb_clint_rtc_gen;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          en_i = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [W-1:0]  cfg_inc_i = '0;
    logic          rtc_o;
    logic          tick_o;
    logic [CW-1:0] edge_cnt_o;

    clint_rtc_gen #(
        .ACC_WIDTH  (W),
        .DEFAULT_INC(8'd64),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_inc_i  (cfg_inc_i),
        .rtc_o      (rtc_o),
        .tick_o     (tick_o),
        .edge_cnt_o (edge_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rtc;
        logic       tick;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model of the generator
    int m_acc = 0, m_inc = 64, m_pend = 0, m_pend_inc = 0;
    int m_rtc = 0, m_tick = 0, m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [W-1:0] d);
        exp_t x;
        int   s;
        logic carry, rise, app, xfer;
        rst_i = r; en_i = e; cfg_valid_i = v; cfg_inc_i = d;
        #1;
        chk("ready", {31'd0, cfg_ready_o}, {31'd0, (!r && m_pend == 0)});
        if (r) begin
            m_acc = 0; m_inc = 64; m_pend = 0; m_pend_inc = 0;
            m_rtc = 0; m_tick = 0; m_cnt = 0;
        end else begin
            xfer  = v && (m_pend == 0);
            s     = m_acc + m_inc;
            carry = e && (s >= (1 << W));
            rise  = carry && (m_rtc == 0);
            app   = (m_pend != 0) && (rise || !e || m_inc == 0);
            if (xfer) begin
                m_pend = 1; m_pend_inc = int'(d);
                $display("cfg write inc=%0d t=%0t", d, $time);
            end else if (app) begin
                m_pend = 0; m_inc = m_pend_inc;
                $display("cfg apply inc=%0d t=%0t", m_inc, $time);
            end
            if (e) begin
                m_acc  = s % (1 << W);
                if (carry) m_rtc = 1 - m_rtc;
                m_tick = rise ? 1 : 0;
                if (rise) m_cnt = (m_cnt + 1) % (1 << CW);
            end else begin
                m_acc = 0; m_rtc = 0; m_tick = 0;
            end
        end
        x.rtc = m_rtc[0]; x.tick = m_tick[0]; x.cnt = m_cnt[3:0];
        sb.push_back(x);
        @(posedge clk_i);
        #1;
        x = sb.pop_front();
        chk("rtc",  {31'd0, rtc_o},      {31'd0, x.rtc});
        chk("tick", {31'd0, tick_o},     {31'd0, x.tick});
        chk("cnt",  {28'd0, edge_cnt_o}, {28'd0, x.cnt});
    endtask

    // Run enabled with no request until the model reaches the wanted rtc level.
    task automatic run_until_rtc(input int lvl);
        int n;
        n = 0;
        while (m_rtc != lvl && n < 100) begin
            step(0, 1, 0, '0);
            n++;
        end
        if (n == 100) begin
            total++; bad++;
            $display("FAIL wait_rtc got=timeout want=level%0d", lvl);
        end
    endtask

    task automatic run_until_applied();
        int n;
        n = 0;
        while (m_pend != 0 && n < 100) begin
            step(0, 1, 0, '0);
            n++;
        end
        if (n == 100) begin
            total++; bad++;
            $display("FAIL wait_apply got=timeout want=applied");
        end
    endtask

    int saved_cnt;

    initial begin
        // Reset; outputs zero and ready low during reset
        step(1, 0, 1, 8'd99);
        step(1, 0, 0, '0);
        chk("rst_rtc", {31'd0, rtc_o}, 32'd0);
        chk("rst_cnt", {28'd0, edge_cnt_o}, 32'd0);

        // 1: default increment 64 -> period 8, 4 rises in 32 cycles
        for (int i = 0; i < 32; i++) step(0, 1, 0, '0);
        chk("t1_cnt", {28'd0, edge_cnt_o}, 32'd4);
        chk("t1_rtc", {31'd0, rtc_o}, 32'd0);

        // 2: write 128 during high phase; requester holds valid while not ready
        run_until_rtc(1);
        step(0, 1, 1, 8'd128);
        chk("t2_ready_low", {31'd0, cfg_ready_o}, 32'd0);
        step(0, 1, 1, 8'd7);
        step(0, 1, 1, 8'd7);
        run_until_applied();
        chk("t2_inc", m_inc, 32'd128);
        for (int i = 0; i < 12; i++) step(0, 1, 0, '0);

        // 3: zero increment freezes rtc; a new value applies immediately
        step(0, 1, 1, 8'd0);
        run_until_applied();
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
        step(0, 1, 1, 8'd64);
        step(0, 1, 0, '0);
        chk("t3_ready_back", {31'd0, cfg_ready_o}, 32'd1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, '0);

        // 4: disable while high with a pending write, then re-enable
        run_until_rtc(1);
        step(0, 1, 1, 8'd64);
        saved_cnt = m_cnt;
        step(0, 0, 0, '0);
        chk("t4_rtc_off", {31'd0, rtc_o}, 32'd0);
        chk("t4_cnt_hold", {28'd0, edge_cnt_o}, saved_cnt);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        chk("t4_no_rise_yet", {31'd0, rtc_o}, 32'd0);
        step(0, 1, 0, '0);
        chk("t4_rise", {31'd0, rtc_o}, 32'd1);
        chk("t4_tick", {31'd0, tick_o}, 32'd1);

        // 5: reset with a pending value while high; pending is discarded
        step(0, 1, 1, 8'd128);
        step(1, 1, 1, 8'd200);
        chk("t5_rtc", {31'd0, rtc_o}, 32'd0);
        chk("t5_cnt", {28'd0, edge_cnt_o}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
        chk("t5_first_rise", {31'd0, tick_o}, 32'd1);

        // 6: inc=128 for 64 cycles -> 16 rises, counter wraps back to start value
        step(0, 1, 1, 8'd128);
        run_until_applied();
        saved_cnt = m_cnt;
        for (int i = 0; i < 64; i++) step(0, 1, 0, '0);
        chk("t6_wrap", {28'd0, edge_cnt_o}, saved_cnt);

        // Random traffic, including increments above the useful maximum
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 90),
                 ($urandom_range(0, 99) < 15), 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
